paddle_pos_ctrl: RTL and testbench
==================================

Name: paddle_pos_ctrl

Overview:
- Converts digital up/down controls (keyboard or joystick) into saturating vertical paddle positions, one per channel.
- Drives the game core's paddle1_vpos/paddle2_vpos inputs, and further positions for multi-player cores.
- Generalises the fixed two-player button path to N channels, configurable position width and limits, rate-divided stepping and hold-to-accelerate.
- Sits between the input mapping logic and the game core, in the clk_sys domain.

Parameters:
- CHANNELS, 2, number of independent paddles.
- POS_W, 8, position width in bits.
- POS_MIN, 0, lowest legal position.
- POS_MAX, 255, highest legal position; requires POS_MIN < POS_MAX < 2^POS_W.
- POS_INIT, 128, position after reset or centre request.
- TICK_DIV, 12000, clk_sys cycles per step tick; must be >= 2.
- SLOW_STEP, 1, position delta per tick in SLOW.
- FAST_STEP, 4, position delta per tick in FAST.
- HOLD_TICKS, 16, consecutive same-direction ticks in SLOW before entering FAST.

Ports:
- clk_sys, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- up, in, CHANNELS, per-channel up request, level.
- down, in, CHANNELS, per-channel down request, level.
- center, in, CHANNELS, per-channel recentre pulse.
- pos, out, CHANNELS*POS_W, positions; channel k occupies bits [k*POS_W +: POS_W].
- at_limit, out, CHANNELS, high while channel position equals POS_MIN or POS_MAX.
- tick, out, 1, one-cycle step strobe.

Behaviour:
- Reset, asynchronous on reset_n low:
  - every pos = POS_INIT.
  - at_limit reflects POS_INIT.
  - tick = 0, divider = 0.
  - every channel state = IDLE, hold counter = 0.
- Divider counts 0..TICK_DIV-1 and wraps to 0. tick is registered high for exactly the one cycle in which the divider equals TICK_DIV-1.
- Inputs are sampled only on a tick cycle; the new pos is visible on the clock after the tick cycle. Between ticks, pos and state hold.
- Direction per channel: dir = UP if up&~down, DOWN if down&~up, otherwise NONE. Up and down together is NONE.
- UP increases pos.
- State machine per channel, evaluated on tick:
  - IDLE:
    - dir NONE: stay in IDLE.
    - dir != NONE: go to SLOW, apply SLOW_STEP, hold = 1, latch dir.
  - SLOW:
    - dir NONE: go to IDLE, hold = 0.
    - dir == latched dir: apply SLOW_STEP and increment hold. When hold reaches HOLD_TICKS, go to FAST. The step on that transition tick is still SLOW_STEP.
    - dir != latched dir (reversal): stay in SLOW, latch new dir, hold = 1, apply SLOW_STEP in the new direction.
  - FAST:
    - same dir: apply FAST_STEP.
    - NONE: go to IDLE.
    - reversal: go to SLOW as above.
- Arithmetic:
  - Computed at POS_W+1 bits, then saturated to [POS_MIN, POS_MAX].
  - A step that would cross a limit lands exactly on that limit.
  - Pushing against a limit keeps pos at the limit and the state machine keeps advancing; no wrap-around.
- center[k]:
  - Any cycle (not only tick): pos[k] = POS_INIT next clock, state[k] = IDLE, hold = 0.
  - center has priority over a coincident tick update on that channel.
- Hold counter saturates at HOLD_TICKS; width is clog2(HOLD_TICKS+1).
- at_limit is combinational from the pos registers.
- reset_n asserted mid-tick or mid-acceleration immediately forces reset values. Release is synchronised internally with a 2-flop deassertion synchroniser; the first tick occurs TICK_DIV cycles after release.

Optional Feature:
- Macro: PADDLE_ANALOG_EN.
- When defined, the block adds these ports:
  - analog, in, CHANNELS*8, signed stick value per channel.
  - analog_mode, in, CHANNELS, selects absolute positioning per channel.
- For a channel with analog_mode high, on each tick: pos = POS_MIN + ((analog+128)*(POS_MAX-POS_MIN))>>8, computed unsigned and registered.
  - up/down are ignored and the state is held in IDLE.
  - center still applies.
- When not defined, these ports do not exist and only the digital path is built.

Test Plan:
- Reset: with TICK_DIV=4, hold reset_n low, then release -> pos all 128, at_limit=0, first tick 4 cycles after synchroniser release, tick period 4 cycles.
- Acceleration: up[0]=1 held for 20 ticks, defaults -> pos0 = 128+16*1+4*4 = 160; transition into FAST after the 16th tick; pos1 stays 128.
- Saturation and reversal:
  - down[1] held from 128 -> reaches 0, at_limit[1]=1, stays 0.
  - switch to up[1] -> next tick pos1=1 (SLOW, hold=1).
- Conflict and centre:
  - up&down on channel 0 -> pos unchanged, state IDLE.
  - center[0] pulsed on a tick cycle while up[0]=1 -> pos0=128 next clock.
- Reset mid-operation: assert reset_n low while channel 0 is in FAST at pos 200 -> pos0=128 asynchronously, state IDLE after release.
- PADDLE_ANALOG_EN, analog_mode[0]=1:
  - analog=-128 -> pos0=0.
  - analog=0 -> pos0=127.
  - analog=127 -> pos0=254.
  - Each update is visible one clock after the tick.

Source files
------------

// File: rtl/paddle_pos_ctrl.sv
// paddle_pos_ctrl: turns per-channel up/down levels into saturating paddle
// positions, stepped on a divided tick with hold-to-accelerate.
// Optional build macro PADDLE_ANALOG_EN adds per-channel absolute (analog
// stick) positioning through i_analog / i_analog_mode.
//
// Per-channel state | meaning
//   S_IDLE          | no direction held, position static
//   S_SLOW          | moving by SLOW_STEP, counting consecutive ticks
//   S_FAST          | held long enough, moving by FAST_STEP
module paddle_pos_ctrl #(
  parameter int CHANNELS   = 2,
  parameter int POS_W      = 8,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 255,
  parameter int POS_INIT   = 128,
  parameter int TICK_DIV   = 12000,
  parameter int SLOW_STEP  = 1,
  parameter int FAST_STEP  = 4,
  parameter int HOLD_TICKS = 16
) (
  input  logic                      i_clk_sys,
  input  logic                      i_reset_n,
  input  logic [CHANNELS-1:0]       i_up,
  input  logic [CHANNELS-1:0]       i_down,
  input  logic [CHANNELS-1:0]       i_center,
`ifdef PADDLE_ANALOG_EN
  input  logic [CHANNELS*8-1:0]     i_analog,
  input  logic [CHANNELS-1:0]       i_analog_mode,
`endif
  output logic [CHANNELS*POS_W-1:0] o_pos,
  output logic [CHANNELS-1:0]       o_at_limit,
  output logic                      o_tick
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SLOW = 2'd1;
  localparam logic [1:0] S_FAST = 2'd2;

  localparam logic [POS_W:0]   P_MIN    = (POS_W+1)'(POS_MIN);
  localparam logic [POS_W:0]   P_MAX    = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W:0]   P_SLOW   = (POS_W+1)'(SLOW_STEP);
  localparam logic [POS_W:0]   P_FAST   = (POS_W+1)'(FAST_STEP);
  localparam logic [POS_W-1:0] P_INIT   = POS_W'(POS_INIT);
  localparam logic [POS_W-1:0] P_MIN_N  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX_N  = POS_W'(POS_MAX);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [DIV_W-1:0] r_div;
  logic             r_tick;

  // reset asserts immediately, deasserts two clocks after release
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // tick divider; tick is registered so it coincides with div == TICK_DIV-1
  always_ff @(posedge i_clk_sys or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      if (r_div == DIV_W'(TICK_DIV - 1)) r_div <= '0;
      else                               r_div <= r_div + 1'b1;
      r_tick <= (r_div == DIV_W'(TICK_DIV - 2));
    end
  end

  assign o_tick = r_tick;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [POS_W-1:0]  r_pos;
    logic [1:0]        r_state;
    logic              r_dir_up;
    logic [HOLD_W-1:0] r_hold;

    logic              w_dir_up, w_dir_dn, w_any;
    logic [1:0]        w_state_nx;
    logic              w_dir_nx;
    logic [HOLD_W-1:0] w_hold_nx, w_hold_inc;
    logic              w_move, w_fast;
    logic [POS_W:0]    w_ext, w_step, w_sum, w_floor, w_res;
    logic              w_an;
    logic [POS_W-1:0]  w_an_pos;

    assign w_dir_up   = i_up[k] & ~i_down[k];
    assign w_dir_dn   = i_down[k] & ~i_up[k];
    assign w_any      = w_dir_up | w_dir_dn;
    assign w_hold_inc = (r_hold >= HOLD_MAX) ? HOLD_MAX : r_hold + 1'b1;

    // direction and acceleration decision applied on the next tick
    always_comb begin
      w_state_nx = r_state;
      w_dir_nx   = r_dir_up;
      w_hold_nx  = r_hold;
      w_move     = 1'b0;
      w_fast     = 1'b0;
      if (!w_any) begin
        w_state_nx = S_IDLE;
        w_hold_nx  = '0;
      end else if (r_state == S_IDLE || w_dir_up != r_dir_up) begin
        // fresh press or reversal restarts the hold count
        w_move     = 1'b1;
        w_dir_nx   = w_dir_up;
        w_hold_nx  = HOLD_ONE;
        w_state_nx = (HOLD_TICKS <= 1) ? S_FAST : S_SLOW;
      end else if (r_state == S_FAST) begin
        w_move = 1'b1;
        w_fast = 1'b1;
      end else begin
        // the step on the tick that reaches HOLD_TICKS is still slow
        w_move     = 1'b1;
        w_hold_nx  = w_hold_inc;
        w_state_nx = (w_hold_inc >= HOLD_MAX) ? S_FAST : S_SLOW;
      end
    end

    assign w_ext   = {1'b0, r_pos};
    assign w_step  = w_fast ? P_FAST : P_SLOW;
    assign w_sum   = w_ext + w_step;
    assign w_floor = P_MIN + w_step;

    // one extra bit of headroom, then clamp onto the nearer limit
    always_comb begin
      w_res = w_ext;
      if (w_move) begin
        if (w_dir_up) w_res = (w_sum > P_MAX) ? P_MAX : w_sum;
        else          w_res = (w_ext < w_floor) ? P_MIN : (w_ext - w_step);
      end
    end

`ifdef PADDLE_ANALOG_EN
    localparam logic [POS_W+8:0] P_RANGE = (POS_W+9)'(POS_MAX - POS_MIN);
    logic [7:0]       w_an_off;
    logic [POS_W+8:0] w_prod;
    assign w_an     = i_analog_mode[k];
    // flipping the sign bit maps -128..127 onto 0..255
    assign w_an_off = i_analog[k*8 +: 8] ^ 8'h80;
    assign w_prod   = {{(POS_W+1){1'b0}}, w_an_off} * P_RANGE;
    assign w_an_pos = P_MIN_N + w_prod[POS_W+7:8];
`else
    assign w_an     = 1'b0;
    assign w_an_pos = '0;
`endif

    // position/state update: centre wins over any coincident tick
    always_ff @(posedge i_clk_sys or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_pos    <= P_INIT;
        r_state  <= S_IDLE;
        r_dir_up <= 1'b0;
        r_hold   <= '0;
      end else if (i_center[k]) begin
        r_pos   <= P_INIT;
        r_state <= S_IDLE;
        r_hold  <= '0;
      end else if (r_tick) begin
        if (w_an) begin
          r_pos   <= w_an_pos;
          r_state <= S_IDLE;
          r_hold  <= '0;
        end else begin
          r_pos    <= w_res[POS_W-1:0];
          r_state  <= w_state_nx;
          r_dir_up <= w_dir_nx;
          r_hold   <= w_hold_nx;
        end
      end
    end

    assign o_pos[k*POS_W +: POS_W] = r_pos;
    assign o_at_limit[k]           = (r_pos == P_MIN_N) || (r_pos == P_MAX_N);
  end

endmodule

// File: tb/tb_paddle_pos_ctrl.sv
// Bench for paddle_pos_ctrl: directed scenarios plus random up/down/centre
// traffic, all compared against a run-length model of paddle motion.
module tb_paddle_pos_ctrl;
  localparam int CH    = 2;
  localparam int PW    = 8;
  localparam int PMIN  = 0;
  localparam int PMAX  = 255;
  localparam int PINIT = 128;
  localparam int TDIV  = 4;
  localparam int SLOW  = 1;
  localparam int FAST  = 4;
  localparam int HOLD  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CH-1:0]    up, dn, ctr;
  logic [CH*PW-1:0] pos;
  logic [CH-1:0]    lim;
  logic             tick;
`ifdef PADDLE_ANALOG_EN
  logic [CH*8-1:0]  analog;
  logic [CH-1:0]    amode;
`endif

  int checks = 0;
  int errors = 0;

  // model: position, consecutive same-direction tick count, last direction
  int m_pos[CH];
  int m_run[CH];
  int m_prev[CH];

  always #5 clk = ~clk;

  paddle_pos_ctrl #(
    .CHANNELS(CH), .POS_W(PW), .POS_MIN(PMIN), .POS_MAX(PMAX),
    .POS_INIT(PINIT), .TICK_DIV(TDIV), .SLOW_STEP(SLOW),
    .FAST_STEP(FAST), .HOLD_TICKS(HOLD)
  ) dut (
    .i_clk_sys(clk),
    .i_reset_n(rst_n),
    .i_up(up),
    .i_down(dn),
    .i_center(ctr),
`ifdef PADDLE_ANALOG_EN
    .i_analog(analog),
    .i_analog_mode(amode),
`endif
    .o_pos(pos),
    .o_at_limit(lim),
    .o_tick(tick)
  );

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_pos[k] = PINIT; m_run[k] = 0; m_prev[k] = 0;
    end
  endtask

  task automatic model_tick(input logic [CH-1:0] u, input logic [CH-1:0] d,
                            input logic [CH-1:0] c);
    int dir, step, np;
    for (int k = 0; k < CH; k++) begin
      if (c[k]) begin
        m_pos[k] = PINIT; m_run[k] = 0; m_prev[k] = 0;
      end else begin
        dir = (u[k] && !d[k]) ? 1 : ((d[k] && !u[k]) ? -1 : 0);
        if (dir == 0) begin
          m_run[k] = 0; m_prev[k] = 0;
        end else begin
          m_run[k]  = (dir == m_prev[k]) ? m_run[k] + 1 : 1;
          m_prev[k] = dir;
          step      = (m_run[k] > HOLD) ? FAST : SLOW;
          np        = m_pos[k] + dir * step;
          if (np > PMAX) np = PMAX;
          if (np < PMIN) np = PMIN;
          m_pos[k] = np;
        end
      end
    end
  endtask

  // find the next tick cycle, drive the inputs it will sample, step the
  // model, and return on the negedge after the update edge
  task automatic drive_tick(input logic [CH-1:0] u, input logic [CH-1:0] d,
                            input logic [CH-1:0] c);
    bit found = 0;
    for (int n = 0; n < 2*TDIV + 4; n++) begin
      @(negedge clk);
      if (tick === 1'b1) begin found = 1; break; end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL tick_timeout no tick within %0d cycles", 2*TDIV + 4);
    end
    up = u; dn = d; ctr = c;
    model_tick(u, d, c);
    @(negedge clk);
    ctr = '0;
  endtask

  task automatic test_reset();
    int first, period;
    logic [PW-1:0] got;
    rst_n = 1'b0; up = '0; dn = '0; ctr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < CH; k++) begin
      got = pos[k*PW +: PW];
      checks++;
      if (got !== PW'(PINIT)) begin
        errors++; $display("FAIL reset_pos%0d got %0d exp %0d", k, got, PINIT);
      end
    end
    checks++;
    if (lim !== '0) begin errors++; $display("FAIL reset_limit got %b exp 0", lim); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
    rst_n = 1'b1;
    first = -1;
    for (int n = 1; n <= 4*TDIV; n++) begin
      @(posedge clk); #1;
      if (tick === 1'b1) begin first = n; break; end
    end
    // two synchroniser edges, then TICK_DIV-1 counting edges
    checks++;
    if (first !== TDIV + 1) begin
      errors++; $display("FAIL first_tick got edge %0d exp edge %0d", first, TDIV + 1);
    end
    period = -1;
    for (int n = 1; n <= 4*TDIV; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL tick_width got %b exp 0", tick); end
      end
      if (tick === 1'b1) begin period = n; break; end
    end
    checks++;
    if (period !== TDIV) begin
      errors++; $display("FAIL tick_period got %0d exp %0d", period, TDIV);
    end
  endtask

  task automatic test_accel();
    logic [PW-1:0] got;
    for (int t = 0; t < 20; t++) begin
      drive_tick(2'b01, 2'b00, 2'b00);
      for (int k = 0; k < CH; k++) begin
        got = pos[k*PW +: PW];
        checks++;
        if (got !== PW'(m_pos[k])) begin
          errors++; $display("FAIL accel t%0d pos%0d got %0d exp %0d", t, k, got, m_pos[k]);
        end
      end
    end
    checks++;
    if (pos[7:0] !== 8'd160) begin errors++; $display("FAIL accel_final pos0 got %0d exp 160", pos[7:0]); end
    checks++;
    if (pos[15:8] !== 8'd128) begin errors++; $display("FAIL accel_final pos1 got %0d exp 128", pos[15:8]); end
  endtask

  task automatic test_saturation();
    logic [PW-1:0] got;
    for (int t = 0; t < 50; t++) begin
      drive_tick(2'b00, 2'b10, 2'b00);
      for (int k = 0; k < CH; k++) begin
        got = pos[k*PW +: PW];
        checks++;
        if (got !== PW'(m_pos[k])) begin
          errors++; $display("FAIL sat t%0d pos%0d got %0d exp %0d", t, k, got, m_pos[k]);
        end
        checks++;
        if (lim[k] !== (m_pos[k] == PMIN || m_pos[k] == PMAX)) begin
          errors++; $display("FAIL sat_limit t%0d ch%0d got %b", t, k, lim[k]);
        end
      end
    end
    checks++;
    if (pos[15:8] !== 8'd0 || lim[1] !== 1'b1) begin
      errors++; $display("FAIL sat_floor pos1 got %0d lim %b exp 0 lim 1", pos[15:8], lim[1]);
    end
    drive_tick(2'b10, 2'b00, 2'b00);
    checks++;
    if (pos[15:8] !== 8'd1 || lim[1] !== 1'b0) begin
      errors++; $display("FAIL reversal pos1 got %0d lim %b exp 1 lim 0", pos[15:8], lim[1]);
    end
  endtask

  task automatic test_conflict();
    for (int t = 0; t < 5; t++) begin
      drive_tick(2'b01, 2'b01, 2'b00);
      checks++;
      if (pos[7:0] !== 8'd160 || pos[7:0] !== PW'(m_pos[0])) begin
        errors++; $display("FAIL conflict t%0d pos0 got %0d exp 160", t, pos[7:0]);
      end
    end
    // conflict left the channel idle, so the next press is a slow step
    drive_tick(2'b01, 2'b00, 2'b00);
    checks++;
    if (pos[7:0] !== 8'd161) begin errors++; $display("FAIL conflict_idle pos0 got %0d exp 161", pos[7:0]); end
  endtask

  task automatic test_center();
    drive_tick(2'b01, 2'b00, 2'b01);
    checks++;
    if (pos[7:0] !== 8'd128) begin errors++; $display("FAIL center_tick pos0 got %0d exp 128", pos[7:0]); end
    drive_tick(2'b01, 2'b00, 2'b00);
    checks++;
    if (pos[7:0] !== 8'd129) begin errors++; $display("FAIL center_after pos0 got %0d exp 129", pos[7:0]); end
    ctr = 2'b01;
    @(negedge clk);
    ctr = 2'b00;
    m_pos[0] = PINIT; m_run[0] = 0; m_prev[0] = 0;
    checks++;
    if (pos[7:0] !== 8'd128) begin errors++; $display("FAIL center_async pos0 got %0d exp 128", pos[7:0]); end
    drive_tick(2'b01, 2'b00, 2'b00);
    checks++;
    if (pos[7:0] !== 8'd129) begin errors++; $display("FAIL center_idle pos0 got %0d exp 129", pos[7:0]); end
  endtask

  task automatic test_reset_mid();
    drive_tick(2'b00, 2'b00, 2'b01);
    for (int t = 0; t < 30; t++) drive_tick(2'b01, 2'b00, 2'b00);
    checks++;
    if (pos[7:0] !== 8'd200 || pos[7:0] !== PW'(m_pos[0])) begin
      errors++; $display("FAIL fast_reach pos0 got %0d exp 200", pos[7:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pos[7:0] !== 8'd128 || tick !== 1'b0) begin
      errors++; $display("FAIL reset_mid pos0 got %0d tick %b exp 128 tick 0", pos[7:0], tick);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_tick(2'b01, 2'b00, 2'b00);
    checks++;
    if (pos[7:0] !== 8'd129) begin errors++; $display("FAIL reset_idle pos0 got %0d exp 129", pos[7:0]); end
  endtask

  task automatic test_random();
    logic [PW-1:0] got;
    logic [CH-1:0] u, d, c;
    for (int t = 0; t < 150; t++) begin
      u = CH'($urandom_range(0, 3));
      d = CH'($urandom_range(0, 3));
      // bias towards holding so acceleration and limits get exercised
      if ($urandom_range(0, 3) != 0) begin u = 2'b11; d = 2'b00; end
      if (t >= 75 && $urandom_range(0, 3) != 0) begin u = 2'b00; d = 2'b11; end
      c = ($urandom_range(0, 15) == 0) ? CH'($urandom_range(1, 3)) : '0;
      drive_tick(u, d, c);
      for (int k = 0; k < CH; k++) begin
        got = pos[k*PW +: PW];
        checks++;
        if (got !== PW'(m_pos[k]) || lim[k] !== (m_pos[k] == PMIN || m_pos[k] == PMAX)) begin
          errors++;
          $display("FAIL random t%0d pos%0d got %0d lim %b exp %0d", t, k, got, lim[k], m_pos[k]);
        end
      end
    end
  endtask

`ifdef PADDLE_ANALOG_EN
  task automatic test_analog();
    logic [7:0] av[3];
    int         ae[3];
    av[0] = 8'h80; av[1] = 8'h00; av[2] = 8'h7F;
    ae[0] = 0;     ae[1] = 127;   ae[2] = 254;
    amode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      analog[7:0] = av[i];
      drive_tick(2'b01, 2'b00, 2'b00);
      m_pos[0] = ae[i]; m_run[0] = 0; m_prev[0] = 0;
      checks++;
      if (pos[7:0] !== PW'(ae[i]) || pos[15:8] !== PW'(m_pos[1])) begin
        errors++; $display("FAIL analog%0d pos0 got %0d exp %0d", i, pos[7:0], ae[i]);
      end
    end
    amode = 2'b00;
    drive_tick(2'b01, 2'b00, 2'b00);
    checks++;
    if (pos[7:0] !== 8'd255 || lim[0] !== 1'b1) begin
      errors++; $display("FAIL analog_exit pos0 got %0d lim %b exp 255 lim 1", pos[7:0], lim[0]);
    end
  endtask
`endif

  initial begin
`ifdef PADDLE_ANALOG_EN
    analog = '0; amode = '0;
`endif
    test_reset();
    test_accel();
    test_saturation();
    test_conflict();
    test_center();
    test_reset_mid();
    test_random();
`ifdef PADDLE_ANALOG_EN
    test_analog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
